counter_mod_step: RTL and testbench
===================================

Name: counter_mod_step

Overview:
Parametrised successor to the team's up/down loadable counter. Adds generic WIDTH, programmable modulus (max_val), programmable step, selectable wrap or saturate mode, terminal-count flags, a wrap/clip event pulse and a sticky overflow flag. Used as a general event and timebase counter inside datapath blocks, and is a drop-in superset of the basic counter's load_n/up_down/ce/data_load interface.

Parameters:
WIDTH, 8, counter and data width in bits
STEP_W, 4, width of the step input
PRESCALE, 4, ce divide ratio; used only when COUNTER_PRESCALE_EN is defined; must be >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
load_n  in  1  synchronous load, active low
up_down  in  1  1 = count up, 0 = count down
ce  in  1  count enable
data_load  in  WIDTH  load value
max_val  in  WIDTH  modulus: legal range 0..max_val
step  in  STEP_W  increment/decrement amount
mode  in  1  mode_e: 0 = MODE_WRAP, 1 = MODE_SAT
clr_ovf  in  1  clears ovf_sticky
count_out  out  WIDTH  registered count
max_count  out  1  count_out == max_val (combinational from register)
zero  out  1  count_out == 0 (combinational from register)
wrap_evt  out  1  registered 1-cycle pulse per wrap/clip event
ovf_sticky  out  1  sticky event flag

Behaviour:
- One clock; reset is asynchronous and active-high. rst asserted: count_out=0, wrap_evt=0, ovf_sticky=0 immediately, independent of clk. Derived flags follow: zero=1, max_count=(max_val==0).
- Priority per rising edge: rst > load_n=0 > counting (ce=1) > hold.
- Load: count_out <= min(data_load, max_val). Loads ignore ce, produce no event and leave ovf_sticky unchanged.
- Effective step: s = min(step, max_val), zero-extended. All sums are computed in WIDTH+1 bits; no intermediate truncation.
- Out-of-range count: if count_out > max_val on a counting cycle (max_val lowered at runtime), next count = max_val in either direction and either mode, and the cycle is an event.
- Up count: if count_out+s <= max_val, next = count_out+s. Otherwise an event occurs. WRAP: next = count_out+s-(max_val+1). SAT: next = max_val.
- Down count: if count_out >= s, next = count_out-s. Otherwise an event occurs. WRAP: next = count_out+(max_val+1)-s. SAT: next = 0.
- Saturated hold: SAT mode sitting at a limit and pushed further is an event every counting cycle.
- s=0 holds the count with no event. max_val=0 therefore pins the count at 0.
- Event timing: wrap_evt is high for exactly the cycle after the edge that applied the wrapped or clipped value. Back-to-back events keep wrap_evt high continuously.
- ovf_sticky: set on the same edge wrap_evt is registered high. clr_ovf=1 clears it, except that a simultaneous event wins and the flag stays 1.
- mode, step and max_val are sampled each edge with no internal latching. Changes take effect on the next counting edge.
- Latency: one cycle from ce/load_n to count_out.

Optional Feature:
- Macro COUNTER_PRESCALE_EN.
- Defined: an internal prescaler counts ce-high cycles. Counting happens only on the PRESCALE-th ce-high cycle, then the prescaler returns to 0. The prescaler is cleared by rst and by load. ce low freezes the prescaler.
- Undefined: every ce-high cycle counts, the prescaler is not instantiated, and the PRESCALE parameter is ignored.

Decomposition:
- Shared package: typedef enum logic {MODE_WRAP, MODE_SAT} mode_e, plus default width constants.
- Sub-module counter_prescaler, instantiated only under COUNTER_PRESCALE_EN. Ports: clk, rst, clr, ce_in, ce_out.

Test Plan:
- Async reset: count at 37, pulse rst=1 between edges -> count_out=0 and zero=1 immediately; wrap_evt=0, ovf_sticky=0.
- Wrap up: WIDTH=8, max_val=9, MODE_WRAP, step=3, load 8, then ce=1, up_down=1 -> count 8 then 1 then 4; wrap_evt high one cycle after the 8->1 edge; ovf_sticky=1.
- Saturate down: MODE_SAT, count 2, step=5, down -> 0 with event; next cycle stays 0 with event again; max_val=0 with step=3 -> holds 0, no event.
- Load clamp and priority: max_val=150, data_load=200, load_n=0, ce=1 -> count_out=150, max_count=1, no event. Then lower max_val to 100 and count -> 100 with event.
- Sticky race: clr_ovf=1 on the same edge as a wrap -> ovf_sticky stays 1. clr_ovf=1 with no event -> 0.
- Prescaler (macro defined, PRESCALE=4): from 0, step=1, up, ce held 8 cycles -> count_out=2. Same stimulus without the macro -> 8. A load mid-sequence restarts the 4-cycle phase.

Source files
------------

// File: rtl/counter_mod_step_pkg.sv
// Shared types and default sizes for the modulo/step counter.
package counter_mod_step_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam int unsigned DEFAULT_STEP_W   = 4;
    localparam int unsigned DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/counter_prescaler.sv
// Divides count-enable pulses: ce_out fires on every PRESCALE-th ce_in-high cycle.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic ce_in,
    output logic ce_out
);

    localparam int unsigned PW = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] div_q, div_d;
    logic          at_last;

    assign at_last = (div_q == LAST);
    assign ce_out  = ce_in && at_last;

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (ce_in) begin
            div_d = at_last ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/counter_mod_step.sv
// Up/down loadable counter with programmable modulus and step, wrap or saturate mode,
// event pulse and sticky overflow. Define COUNTER_PRESCALE_EN to divide ce by PRESCALE.
module counter_mod_step
    import counter_mod_step_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned STEP_W   = DEFAULT_STEP_W,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_n,
    input  logic             up_down,
    input  logic             ce,
    input  logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] max_val,
    input  logic [STEP_W-1:0] step,
    input  logic             mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count_out,
    output logic             max_count,
    output logic             zero,
    output logic             wrap_evt,
    output logic             ovf_sticky
);

    localparam int unsigned XW = (STEP_W > WIDTH) ? STEP_W + 1 : WIDTH + 1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic             ovf_q, ovf_d;
    logic             cnt_en;
    mode_e            mode_sel;

    logic [XW-1:0] cnt_x, max_x, step_x, data_x, s_x, sum_x;

    assign mode_sel = mode_e'(mode);

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (~load_n),
        .ce_in  (ce),
        .ce_out (cnt_en)
    );
`else
    assign cnt_en = ce;
`endif

    // Widened copies so comparisons and sums never truncate.
    assign cnt_x  = XW'(cnt_q);
    assign max_x  = XW'(max_val);
    assign step_x = XW'(step);
    assign data_x = XW'(data_load);
    assign s_x    = (step_x > max_x) ? max_x : step_x;
    assign sum_x  = cnt_x + s_x;

    always_comb begin
        cnt_d = cnt_q;
        evt_d = 1'b0;
        if (!load_n) begin
            cnt_d = (data_x > max_x) ? max_val : data_load;
        end else if (cnt_en) begin
            if (cnt_x > max_x) begin
                // max_val was lowered below the current count
                cnt_d = max_val;
                evt_d = 1'b1;
            end else if (up_down) begin
                if (sum_x <= max_x) begin
                    cnt_d = WIDTH'(sum_x);
                end else begin
                    evt_d = 1'b1;
                    cnt_d = (mode_sel == MODE_SAT) ? max_val : WIDTH'(sum_x - (max_x + 1'b1));
                end
            end else begin
                if (cnt_x >= s_x) begin
                    cnt_d = WIDTH'(cnt_x - s_x);
                end else begin
                    evt_d = 1'b1;
                    cnt_d = (mode_sel == MODE_SAT) ? '0 : WIDTH'(cnt_x + max_x + 1'b1 - s_x);
                end
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (evt_d) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            evt_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
            ovf_q <= ovf_d;
        end
    end

    assign count_out  = cnt_q;
    assign max_count  = (cnt_q == max_val);
    assign zero       = (cnt_q == '0);
    assign wrap_evt   = evt_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_counter_mod_step.sv
// Directed self-checking bench for counter_mod_step (WIDTH=8, STEP_W=4, PRESCALE=4).
module tb_counter_mod_step;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned STEP_W   = 4;
    localparam int unsigned PRESCALE = 4;
`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned NCE = PRESCALE;
`else
    localparam int unsigned NCE = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load_n;
    logic             up_down;
    logic             ce;
    logic [WIDTH-1:0] data_load;
    logic [WIDTH-1:0] max_val;
    logic [STEP_W-1:0] step;
    logic             mode;
    logic             clr_ovf;
    logic [WIDTH-1:0] count_out;
    logic             max_count;
    logic             zero;
    logic             wrap_evt;
    logic             ovf_sticky;

    int checks = 0;
    int errors = 0;

    counter_mod_step #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_n     (load_n),
        .up_down    (up_down),
        .ce         (ce),
        .data_load  (data_load),
        .max_val    (max_val),
        .step       (step),
        .mode       (mode),
        .clr_ovf    (clr_ovf),
        .count_out  (count_out),
        .max_count  (max_count),
        .zero       (zero),
        .wrap_evt   (wrap_evt),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] val);
        load_n    = 1'b0;
        data_load = val;
        tick();
        load_n    = 1'b1;
    endtask

    // One effective counting edge (PRESCALE ce cycles when the prescaler is built in).
    task automatic count_once();
        ce = 1'b1;
        repeat (NCE) tick();
        ce = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_n = 1'b1; up_down = 1'b1; ce = 1'b0; data_load = '0;
        max_val = 8'd9; step = 4'd1; mode = 1'b0; clr_ovf = 1'b0;
        #12;
        check_val("rst_count", count_out, 0);
        check_val("rst_zero", zero, 1);
        check_val("rst_maxc", max_count, 0);
        check_val("rst_evt", wrap_evt, 0);
        check_val("rst_ovf", ovf_sticky, 0);
        rst = 1'b0;

        // Asynchronous reset between edges
        max_val = 8'd100;
        do_load(8'd37);
        check_val("load37", count_out, 37);
        #2 rst = 1'b1;
        #1;
        check_val("async_count", count_out, 0);
        check_val("async_zero", zero, 1);
        rst = 1'b0;

        // Wrap up: 8 -> 1 -> 4
        max_val = 8'd9; mode = 1'b0; step = 4'd3; up_down = 1'b1;
        do_load(8'd8);
        check_val("wrap_ld", count_out, 8);
        check_val("wrap_ld_evt", wrap_evt, 0);
        count_once();
        check_val("wrap_1", count_out, 1);
        check_val("wrap_1_evt", wrap_evt, 1);
        check_val("wrap_1_ovf", ovf_sticky, 1);
        count_once();
        check_val("wrap_4", count_out, 4);
        check_val("wrap_4_evt", wrap_evt, 0);
        check_val("wrap_4_ovf", ovf_sticky, 1);

        // Sticky clear without event, then clear racing an event
        clr_ovf = 1'b1;
        tick();
        check_val("clr_ovf", ovf_sticky, 0);
        clr_ovf = 1'b0;
        do_load(8'd7);
        clr_ovf = 1'b1;
        count_once();
        check_val("race_count", count_out, 0);
        check_val("race_evt", wrap_evt, 1);
        check_val("race_ovf", ovf_sticky, 1);
        tick();
        check_val("race_clr", ovf_sticky, 0);
        check_val("race_evt_off", wrap_evt, 0);
        clr_ovf = 1'b0;

        // Saturate down, then saturated hold, then max_val=0
        mode = 1'b1; step = 4'd5; up_down = 1'b0;
        do_load(8'd2);
        count_once();
        check_val("sat_0", count_out, 0);
        check_val("sat_0_evt", wrap_evt, 1);
        count_once();
        check_val("sat_hold", count_out, 0);
        check_val("sat_hold_evt", wrap_evt, 1);
        max_val = 8'd0; step = 4'd3;
        count_once();
        check_val("max0_count", count_out, 0);
        check_val("max0_evt", wrap_evt, 0);
        check_val("max0_maxc", max_count, 1);

        // Load clamp with ce high, then lowered modulus
        max_val = 8'd150; data_load = 8'd200; load_n = 1'b0; ce = 1'b1;
        tick();
        load_n = 1'b1; ce = 1'b0;
        check_val("clamp", count_out, 150);
        check_val("clamp_maxc", max_count, 1);
        check_val("clamp_evt", wrap_evt, 0);
        max_val = 8'd100; mode = 1'b0; step = 4'd1; up_down = 1'b1;
        count_once();
        check_val("oor", count_out, 100);
        check_val("oor_evt", wrap_evt, 1);

        // Down wrap: 1 - 3 mod 10 = 8
        max_val = 8'd9; step = 4'd3; up_down = 1'b0; mode = 1'b0;
        do_load(8'd1);
        count_once();
        check_val("dwrap", count_out, 8);
        check_val("dwrap_evt", wrap_evt, 1);

        // Step clamped to max_val=5: 0 -> 5 (no event) -> 4 (wrap)
        max_val = 8'd5; step = 4'd15; up_down = 1'b1;
        do_load(8'd0);
        count_once();
        check_val("sclamp_5", count_out, 5);
        check_val("sclamp_5_evt", wrap_evt, 0);
        count_once();
        check_val("sclamp_4", count_out, 4);
        check_val("sclamp_4_evt", wrap_evt, 1);

        // ce low holds
        tick();
        check_val("hold", count_out, 4);

        // Raw ce run of 8 cycles, then load mid-sequence restarting the phase
        max_val = 8'd255; step = 4'd1; up_down = 1'b1;
        do_load(8'd0);
        ce = 1'b1;
        repeat (8) tick();
        ce = 1'b0;
        check_val("ce8", count_out, (NCE == 1) ? 8 : 2);
        do_load(8'd0);
        ce = 1'b1;
        repeat (3) tick();
        load_n = 1'b0; data_load = 8'd0;
        tick();
        load_n = 1'b1;
        repeat (4) tick();
        ce = 1'b0;
        check_val("phase", count_out, (NCE == 1) ? 4 : 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
